difftest_commit_queue: RTL and testbench
========================================

// Module: difftest_commit_queue
// PURPOSE
//  Multi-lane commit buffer between the core's retire stage and the single-port DifftestInstrCommit sink.
//  Accepts up to COMMIT_WIDTH retired instructions per cycle, compacts them in program order into a FIFO,
//  and drains one per cycle to the sink with a wrapping 8-bit commit index.
//  Backpressure (in_ready) lets retire stall instead of dropping commits when the checker is slow.
// PARAMETERS
//  COMMIT_WIDTH  2   retire lanes per cycle, 1..4; lane 0 is oldest
//  DEPTH         8   FIFO entries; power of two, >= 2*COMMIT_WIDTH
//  XLEN          64  pc/wdata width
// PORTS
//  clock        in   1               single clock, all state on posedge
//  reset        in   1               synchronous, active-high
//  flush        in   1               drop all buffered entries (difftest restart)
//  in_valid     in   W               per-lane commit valid, W=COMMIT_WIDTH
//  in_pc        in   W*XLEN          lane i at [i*XLEN +: XLEN]
//  in_instr     in   W*32            instruction word
//  in_skip      in   W               checker skips this commit (MMIO etc.)
//  in_wen       in   W               GPR write enable
//  in_wdest     in   W*8             destination register
//  in_wdata     in   W*XLEN          writeback data
//  in_ready     out  1               free entries >= COMMIT_WIDTH
//  out_valid    out  1               head entry present
//  out_index    out  8               commit sequence number of head
//  out_pc/out_instr/out_skip/out_wen/out_wdest/out_wdata  out  XLEN/32/1/1/8/XLEN  head entry fields
//  out_ready    in   1               sink accepts head this cycle
//  count        out  clog2(DEPTH)+1  occupied entries
//  overflow     out  1               sticky: valid lanes offered while in_ready=0
// BEHAVIOUR
//  - Reset: count=0, rd/wr ptr=0, seq=0, overflow=0; out_valid=0, out_index=0, in_ready=1; storage not cleared.
//  - in_ready = (DEPTH-count) >= COMMIT_WIDTH, from registered count only (no same-cycle dequeue credit).
//  - Enqueue when in_ready && |in_valid: valid lanes written in lane order to wr_ptr, wr_ptr+1, ...;
//    invalid lanes leave no gap (lanes {0,2} valid -> two consecutive entries). wr_ptr += popcount(in_valid).
//  - Any in_valid with in_ready=0: nothing written, overflow<=1 (cleared only by reset).
//  - Dequeue when out_valid && out_ready: rd_ptr+=1, seq+=1 (8-bit, 255->0). out_index=seq.
//  - Pointers clog2(DEPTH) bits, natural wrap; count tracks fullness: count += enq_n - deq.
//  - Latency: entry written in cycle t visible at head from t+1 (no write-to-read bypass).
//  - out_* fields combinational from storage[rd_ptr]; valid when out_valid=1, don't-care otherwise.
//  - out_valid = (count != 0).
//  - Simultaneous enq+deq: both applied; count nets correctly; never exceeds DEPTH.
//  - flush: ptrs and count -> 0 next cycle; seq retained; overrides same-cycle enq/deq
//    (no dequeue counted, seq not incremented, overflow not set).
//  - reset beats flush; reset mid-drain discards all entries, seq -> 0.
// STRUCTURE
//  - difftest_pkg: commit_entry_t {pc, instr, skip, wen, wdest, wdata}; CMT_IDX_W=8.
//  - Sub-module difftest_commit_compact: per-lane prefix popcount -> write offset and enq_n (combinational).
//  - Top holds storage array of commit_entry_t, pointers, count, seq, overflow.
// TESTING
//  1 W=2: reset, lanes {0,1} valid pc 0x8000_0000/0x8000_0004, out_ready=1 -> heads in that order next
//    cycles, out_index 0 then 1, count 2->1->0.
//  2 Lanes {1} only (pc 0x10) then {0,1} (0x14,0x18) -> dequeued 0x10,0x14,0x18 contiguous, no holes.
//  3 out_ready=0, enqueue 2/cycle: in_ready drops at count=7 (DEPTH=8, free 1<2); offer lane 0 -> overflow=1,
//    count unchanged at 7; raise out_ready -> drains 7 in order, overflow stays 1.
//  4 Steady enq 1/cycle + deq 1/cycle for 300 commits -> out_index wraps 255->0, count constant, no loss.
//  5 count=5, assert flush with valid lanes and out_ready=1 -> next cycle count=0, out_valid=0, out_index unchanged.
//  6 Assert reset during drain with count=4, out_index=3 -> next cycle count=0, out_index=0, overflow=0, in_ready=1.

Source files
------------

// File: rtl/difftest_pkg.sv
// Shared types for the difftest commit path: one buffered commit record and the index width.
package difftest_pkg;
  localparam int CMT_IDX_W = 8;
  localparam int DT_XLEN   = 64;

  typedef struct packed {
    logic [DT_XLEN-1:0] pc;
    logic [31:0]        instr;
    logic               skip;
    logic               wen;
    logic [7:0]         wdest;
    logic [DT_XLEN-1:0] wdata;
  } commit_entry_t;
endpackage

// File: rtl/difftest_commit_queue_if.sv
// Retire-side lanes in, single commit stream out; master = retire/sink side, slave = queue.
interface difftest_commit_queue_if #(
  parameter int COMMIT_WIDTH = 2,
  parameter int DEPTH        = 8,
  parameter int XLEN         = 64
);
  import difftest_pkg::*;

  logic                         flush;
  logic [COMMIT_WIDTH-1:0]      in_valid;
  logic [COMMIT_WIDTH*XLEN-1:0] in_pc;
  logic [COMMIT_WIDTH*32-1:0]   in_instr;
  logic [COMMIT_WIDTH-1:0]      in_skip;
  logic [COMMIT_WIDTH-1:0]      in_wen;
  logic [COMMIT_WIDTH*8-1:0]    in_wdest;
  logic [COMMIT_WIDTH*XLEN-1:0] in_wdata;
  logic                         in_ready;

  logic                         out_valid;
  logic [CMT_IDX_W-1:0]         out_index;
  logic [XLEN-1:0]              out_pc;
  logic [31:0]                  out_instr;
  logic                         out_skip;
  logic                         out_wen;
  logic [7:0]                   out_wdest;
  logic [XLEN-1:0]              out_wdata;
  logic                         out_ready;

  logic [$clog2(DEPTH):0]       count;
  logic                         overflow;

  modport master (
    output flush, in_valid, in_pc, in_instr, in_skip, in_wen, in_wdest, in_wdata, out_ready,
    input  in_ready, out_valid, out_index, out_pc, out_instr, out_skip, out_wen, out_wdest,
           out_wdata, count, overflow
  );

  modport slave (
    input  flush, in_valid, in_pc, in_instr, in_skip, in_wen, in_wdest, in_wdata, out_ready,
    output in_ready, out_valid, out_index, out_pc, out_instr, out_skip, out_wen, out_wdest,
           out_wdata, count, overflow
  );
endinterface

// File: rtl/difftest_commit_compact.sv
// Prefix popcount over lane valids: each lane's slot offset from wr_ptr and the total enqueued.
// Purely combinational; no backpressure of its own.
module difftest_commit_compact #(
  parameter int COMMIT_WIDTH = 2,
  parameter int OFF_W        = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic [COMMIT_WIDTH-1:0]            in_valid_i,
  output logic [COMMIT_WIDTH-1:0][OFF_W-1:0] lane_off_o,
  output logic [OFF_W-1:0]                   enq_n_o
);
  always_comb begin
    logic [OFF_W-1:0] acc;
    acc        = '0;
    lane_off_o = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      lane_off_o[i] = acc;
      acc           = acc + OFF_W'(in_valid_i[i]);
    end
    enq_n_o = acc;
  end
endmodule

// File: rtl/difftest_commit_queue.sv
// Compacting multi-lane commit FIFO draining one entry per cycle with a wrapping 8-bit index.
// Entry visible at head one cycle after write; in_ready from registered count only, so retire stalls rather than drops.
module difftest_commit_queue
  import difftest_pkg::*;
#(
  parameter int COMMIT_WIDTH = 2,
  parameter int DEPTH        = 8,
  parameter int XLEN         = DT_XLEN
) (
  input logic                   clock,
  input logic                   reset,
  difftest_commit_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OFF_W = $clog2(COMMIT_WIDTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(COMMIT_WIDTH);

  commit_entry_t mem_q [DEPTH];
  commit_entry_t lane_ent [COMMIT_WIDTH];
  commit_entry_t head;

  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CMT_IDX_W-1:0] seq_q, seq_d;
  logic                 ovf_q, ovf_d;

  logic [COMMIT_WIDTH-1:0][OFF_W-1:0] lane_off;
  logic [OFF_W-1:0]                   enq_n;
  logic                               in_ready_c;
  logic                               any_vld;
  logic                               enq_fire;
  logic                               deq_fire;

  difftest_commit_compact #(
    .COMMIT_WIDTH (COMMIT_WIDTH),
    .OFF_W        (OFF_W)
  ) u_compact (
    .in_valid_i (bus.in_valid),
    .lane_off_o (lane_off),
    .enq_n_o    (enq_n)
  );

  assign in_ready_c = (DEPTH_C - count_q) >= WIDTH_C;
  assign any_vld    = |bus.in_valid;
  // flush wins over both ports: nothing written, nothing dequeued
  assign enq_fire   = in_ready_c && any_vld && !bus.flush;
  assign deq_fire   = (count_q != '0) && bus.out_ready && !bus.flush;

  always_comb begin
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      lane_ent[i].pc    = bus.in_pc[i*XLEN +: XLEN];
      lane_ent[i].instr = bus.in_instr[i*32 +: 32];
      lane_ent[i].skip  = bus.in_skip[i];
      lane_ent[i].wen   = bus.in_wen[i];
      lane_ent[i].wdest = bus.in_wdest[i*8 +: 8];
      lane_ent[i].wdata = bus.in_wdata[i*XLEN +: XLEN];
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    seq_d    = seq_q;
    ovf_d    = ovf_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(enq_n);
      end
      if (deq_fire) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        seq_d    = seq_q + 1'b1;
      end
      count_d = count_q + (enq_fire ? CNT_W'(enq_n) : '0) - CNT_W'(deq_fire);
      if (any_vld && !in_ready_c) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      seq_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      seq_q    <= seq_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is never cleared; occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clock) begin
    if (enq_fire) begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (bus.in_valid[i]) begin
          mem_q[wr_ptr_q + PTR_W'(lane_off[i])] <= lane_ent[i];
        end
      end
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_index = seq_q;
  assign bus.out_pc    = head.pc;
  assign bus.out_instr = head.instr;
  assign bus.out_skip  = head.skip;
  assign bus.out_wen   = head.wen;
  assign bus.out_wdest = head.wdest;
  assign bus.out_wdata = head.wdata;
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_difftest_commit_queue.sv
// Randomised bench for difftest_commit_queue: stimulus queues expected commits, a negedge monitor
// checks head/index/count/in_ready/overflow against a queue-based reference model.
module tb_difftest_commit_queue;
  import difftest_pkg::*;

  localparam int W  = 2;
  localparam int D  = 8;
  localparam int XL = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  initial forever #5 clk = ~clk;

  difftest_commit_queue_if #(.COMMIT_WIDTH(W), .DEPTH(D), .XLEN(XL)) bus();

  difftest_commit_queue #(.COMMIT_WIDTH(W), .DEPTH(D), .XLEN(XL)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  // Reference model: exp_q holds committed-but-undrained entries in program order.
  commit_entry_t exp_q [$];
  commit_entry_t pend_q [$];
  logic [7:0]    exp_seq  = 8'd0;
  logic          exp_ovf  = 1'b0;
  logic          pend_ovf = 1'b0;
  int            n_chk    = 0;
  int            n_fail   = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
    end
  endfunction

  // Drive one cycle of inputs; predicts acceptance from model occupancy, not from DUT outputs.
  task automatic drive(input logic [W-1:0] v, input logic [63:0] pc0, input logic [63:0] pc1,
                       input logic ordy, input logic fl, input logic rs);
    commit_entry_t e [W];
    logic          acc;
    rst           = rs;
    bus.flush     = fl;
    bus.out_ready = ordy;
    bus.in_valid  = v;
    for (int i = 0; i < W; i++) begin
      e[i].pc    = (i == 0) ? pc0 : pc1;
      e[i].instr = $urandom;
      e[i].skip  = 1'($urandom_range(0, 1));
      e[i].wen   = 1'($urandom_range(0, 1));
      e[i].wdest = 8'($urandom_range(0, 255));
      e[i].wdata = {$urandom, $urandom};
      bus.in_pc[i*XL +: XL]    = e[i].pc;
      bus.in_instr[i*32 +: 32] = e[i].instr;
      bus.in_skip[i]           = e[i].skip;
      bus.in_wen[i]            = e[i].wen;
      bus.in_wdest[i*8 +: 8]   = e[i].wdest;
      bus.in_wdata[i*XL +: XL] = e[i].wdata;
    end
    acc = !rs && !fl && ((D - exp_q.size()) >= W);
    if ((|v) && acc) begin
      for (int i = 0; i < W; i++) begin
        if (v[i]) pend_q.push_back(e[i]);
      end
    end
    if ((|v) && !acc && !fl && !rs) pend_ovf = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int k = 0; k < n; k++) drive('0, 64'd0, 64'd0, ordy, 1'b0, 1'b0);
  endtask

  // Monitor: checks registered state, then advances the model by what the next posedge will do.
  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
      chk("count", 64'(bus.count), 64'(exp_q.size()));
      chk("in_ready", 64'(bus.in_ready), 64'((D - exp_q.size()) >= W));
      chk("overflow", 64'(bus.overflow), 64'(exp_ovf));
      chk("out_index", 64'(bus.out_index), 64'(exp_seq));
      if (exp_q.size() != 0) begin
        chk("head_pc", bus.out_pc, exp_q[0].pc);
        chk("head_instr", 64'(bus.out_instr), 64'(exp_q[0].instr));
        chk("head_wdata", bus.out_wdata, exp_q[0].wdata);
        chk("head_meta", 64'({bus.out_skip, bus.out_wen, bus.out_wdest}),
            64'({exp_q[0].skip, exp_q[0].wen, exp_q[0].wdest}));
      end
      if (rst) begin
        exp_q.delete();
        exp_seq = 8'd0;
        exp_ovf = 1'b0;
      end else if (bus.flush) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() != 0 && bus.out_ready) begin
          void'(exp_q.pop_front());
          exp_seq = exp_seq + 8'd1;
        end
        foreach (pend_q[j]) exp_q.push_back(pend_q[j]);
        if (pend_ovf) exp_ovf = 1'b1;
      end
      pend_q.delete();
      pend_ovf = 1'b0;
    end
  end

  initial begin
    drive('0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    drive('0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);

    // Two lanes in one cycle, drained in order.
    drive(2'b11, 64'h8000_0000, 64'h8000_0004, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 3);

    // Sparse lanes compact with no holes.
    drive(2'b10, 64'd0, 64'h10, 1'b1, 1'b0, 1'b0);
    drive(2'b11, 64'h14, 64'h18, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 4);

    // Fill to 7 with the sink stalled, then offer while not ready.
    drive(2'b01, 64'h100, 64'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) drive(2'b11, 64'h200 + 64'(k*8), 64'h204 + 64'(k*8), 1'b0, 1'b0, 1'b0);
    drive(2'b01, 64'hdead, 64'd0, 1'b0, 1'b0, 1'b0);
    drive(2'b11, 64'hbeef, 64'hcafe, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 9);

    // Steady 1-in/1-out across the 8-bit index wrap.
    for (int k = 0; k < 300; k++) drive(2'b01, 64'h4000 + 64'(k*4), 64'd0, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 3);

    // Flush with five entries while enqueue and dequeue are both requested.
    drive(2'b01, 64'h500, 64'd0, 1'b0, 1'b0, 1'b0);
    drive(2'b11, 64'h504, 64'h508, 1'b0, 1'b0, 1'b0);
    drive(2'b11, 64'h50c, 64'h510, 1'b0, 1'b0, 1'b0);
    drive(2'b11, 64'h514, 64'h518, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 2);

    // Reset mid-drain at count 4 / index 3.
    drive('0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) drive(2'b11, 64'h600 + 64'(k*8), 64'h604 + 64'(k*8), 1'b0, 1'b0, 1'b0);
    drive(2'b01, 64'h700, 64'd0, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 3);
    drive('0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 2);

    // Randomised traffic with occasional flush and reset.
    for (int k = 0; k < 600; k++) begin
      drive(W'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0), ($urandom_range(0, 150) == 0));
    end
    idle(1'b1, 12);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
